// File: rtl/si_frame_rx.sv
// Serial sen/sd frame receiver: shifts in {address, data} MSB first and writes each frame into a register bank.
// Defining SI_RX_SEQ_CHECK_EN enables in-order address checking with err_seq reporting.
module si_frame_rx #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 18,
  parameter int NUM_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sen,
  input  logic              sd,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              frame_valid,
  output logic              err_len,
  output logic              err_seq,
  output logic              done
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int FCNT_W  = $clog2(NUM_FRAMES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_W - 1);
  localparam logic [FCNT_W-1:0] FRAMES_MAX = FCNT_W'(NUM_FRAMES);

  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, TAIL, DONE} state_t;

  state_t              state, state_nxt;
  logic [FRAME_W-1:0]  shreg, shreg_nxt, shift_in;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [FCNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic                mem_rw_nxt, frame_valid_nxt, err_len_nxt;
  logic [ADDR_W-1:0]   mem_a_nxt;
  logic [DATA_W-1:0]   mem_d_nxt;
  logic                bit_in, addr_ok, all_written;

`ifdef SI_RX_SEQ_CHECK_EN
  logic [ADDR_W-1:0]   exp_addr, exp_addr_nxt;
  logic                err_seq_nxt;
  assign addr_ok = (shift_in[FRAME_W-1:DATA_W] == exp_addr);
`else
  assign addr_ok = 1'b1;
  assign err_seq = 1'b0;
`endif

  assign bit_in      = en && !sen;
  assign shift_in    = {shreg[FRAME_W-2:0], sd};
  assign all_written = (frame_cnt == FRAMES_MAX);

  // Next-state and registered-output logic; WRITE outputs are computed on the last-bit edge
  always_comb begin
    state_nxt       = state;
    shreg_nxt       = shreg;
    bit_cnt_nxt     = bit_cnt;
    frame_cnt_nxt   = frame_cnt;
    mem_rw_nxt      = 1'b1;
    mem_a_nxt       = mem_a;
    mem_d_nxt       = mem_d;
    frame_valid_nxt = 1'b0;
    err_len_nxt     = 1'b0;
`ifdef SI_RX_SEQ_CHECK_EN
    exp_addr_nxt    = exp_addr;
    err_seq_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bit_in) begin
          shreg_nxt   = {{(FRAME_W-1){1'b0}}, sd};
          bit_cnt_nxt = CNT_W'(1);
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (!en) begin
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else if (sen) begin
          err_len_nxt = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          shreg_nxt   = shift_in;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_nxt = WRITE;
            if (addr_ok) begin
              mem_rw_nxt      = 1'b0;
              mem_a_nxt       = shift_in[FRAME_W-1:DATA_W];
              mem_d_nxt       = shift_in[DATA_W-1:0];
              frame_valid_nxt = 1'b1;
              if (!all_written) frame_cnt_nxt = frame_cnt + FCNT_W'(1);
`ifdef SI_RX_SEQ_CHECK_EN
              exp_addr_nxt    = exp_addr + ADDR_W'(1);
`endif
            end
`ifdef SI_RX_SEQ_CHECK_EN
            else begin
              err_seq_nxt = 1'b1;
            end
`endif
          end
        end
      end
      // A bit arriving on the edge that ends WRITE means the frame is overlong
      WRITE: begin
        bit_cnt_nxt = '0;
        if (bit_in) begin
          err_len_nxt = 1'b1;
          state_nxt   = TAIL;
        end else begin
          state_nxt = all_written ? DONE : IDLE;
        end
      end
      TAIL: begin
        if (!bit_in) state_nxt = all_written ? DONE : IDLE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      mem_rw      <= 1'b1;
      mem_a       <= '0;
      mem_d       <= '0;
      frame_valid <= 1'b0;
      err_len     <= 1'b0;
      done        <= 1'b0;
`ifdef SI_RX_SEQ_CHECK_EN
      exp_addr    <= '0;
      err_seq     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      frame_cnt   <= frame_cnt_nxt;
      mem_rw      <= mem_rw_nxt;
      mem_a       <= mem_a_nxt;
      mem_d       <= mem_d_nxt;
      frame_valid <= frame_valid_nxt;
      err_len     <= err_len_nxt;
      done        <= (state_nxt == DONE);
`ifdef SI_RX_SEQ_CHECK_EN
      exp_addr    <= exp_addr_nxt;
      err_seq     <= err_seq_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_si_frame_rx.sv
// Scoreboard bench for si_frame_rx: a 3+18 instance (8 frames) and a 5+8 instance (18 frames).
module tb_si_frame_rx;

`ifdef SI_RX_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0 = 1'b0, sen0 = 1'b1, sd0 = 1'b0;
  logic en1 = 1'b0, sen1 = 1'b1, sd1 = 1'b0;

  logic        mem_rw0, frame_valid0, err_len0, err_seq0, done0;
  logic [2:0]  mem_a0;
  logic [17:0] mem_d0;
  logic        mem_rw1, frame_valid1, err_len1, err_seq1, done1;
  logic [4:0]  mem_a1;
  logic [7:0]  mem_d1;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int el_cnt0 = 0, es_cnt0 = 0, el_cnt1 = 0, es_cnt1 = 0;
  int exp_el0 = 0, exp_es0 = 0;
  wr_t q0[$], q1[$];
  wr_t e0, e1;

  si_frame_rx #(.ADDR_W(3), .DATA_W(18), .NUM_FRAMES(8)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .sen(sen0), .sd(sd0),
    .mem_rw(mem_rw0), .mem_a(mem_a0), .mem_d(mem_d0), .frame_valid(frame_valid0),
    .err_len(err_len0), .err_seq(err_seq0), .done(done0));

  si_frame_rx #(.ADDR_W(5), .DATA_W(8), .NUM_FRAMES(18)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .sen(sen1), .sd(sd1),
    .mem_rw(mem_rw1), .mem_a(mem_a1), .mem_d(mem_d1), .frame_valid(frame_valid1),
    .err_len(err_len1), .err_seq(err_seq1), .done(done1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic e, input logic s, input logic d);
    @(negedge clk);
    if (which == 0) begin en0 = e; sen0 = s; sd0 = d; end
    else            begin en1 = e; sen1 = s; sd1 = d; end
  endtask

  task automatic idle(input int which, input int n);
    for (int i = 0; i < n; i++) drive(which, 1'b1, 1'b1, 1'b0);
  endtask

  // Sends nbits MSB first, pushing the expected write when the last frame bit is driven
  task automatic applyStimulus(input int which, input logic [31:0] bits, input int nbits,
                               input bit exp_wr, input int gap);
    int fw, dw;
    logic [31:0] fr;
    wr_t e;
    fw = (which == 1) ? 13 : 21;
    dw = (which == 1) ? 8 : 18;
    for (int i = 0; i < nbits; i++) begin
      drive(which, 1'b1, 1'b0, bits[nbits-1-i]);
      if (exp_wr && i == fw - 1) begin
        fr  = bits >> (nbits - fw);
        e.a = fr >> dw;
        e.d = fr & ((32'd1 << dw) - 32'd1);
        e.c = cyc + 1;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    idle(which, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en0 = 1'b0; sen0 = 1'b1; sd0 = 1'b0;
    en1 = 1'b0; sen1 = 1'b1; sd1 = 1'b0;
    #1;
    checkOutput("rst_mem_rw0", 32'(mem_rw0), 32'd1);
    checkOutput("rst_mem_a0", 32'(mem_a0), 32'd0);
    checkOutput("rst_mem_d0", 32'(mem_d0), 32'd0);
    checkOutput("rst_fv0", 32'(frame_valid0), 32'd0);
    checkOutput("rst_err_len0", 32'(err_len0), 32'd0);
    checkOutput("rst_err_seq0", 32'(err_seq0), 32'd0);
    checkOutput("rst_done0", 32'(done0), 32'd0);
    checkOutput("rst_mem_rw1", 32'(mem_rw1), 32'd1);
    checkOutput("rst_done1", 32'(done1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitors: every write cycle pops the scoreboard and checks address, data and timing
  always @(negedge clk) begin
    if (rst) begin
      if (err_len0) el_cnt0++;
      if (err_seq0) es_cnt0++;
      if (frame_valid0 || !mem_rw0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("[TB] FAIL w0_unexpected: got write a=0x%0h d=0x%0h, expected none", mem_a0, mem_d0);
        end else begin
          e0 = q0.pop_front();
          checkOutput("w0_addr", 32'(mem_a0), e0.a);
          checkOutput("w0_data", 32'(mem_d0), e0.d);
          checkOutput("w0_cycle", 32'(cyc), 32'(e0.c));
          checkOutput("w0_fv", 32'(frame_valid0), 32'd1);
          checkOutput("w0_rw", 32'(mem_rw0), 32'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (err_len1) el_cnt1++;
      if (err_seq1) es_cnt1++;
      if (frame_valid1 || !mem_rw1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("[TB] FAIL w1_unexpected: got write a=0x%0h d=0x%0h, expected none", mem_a1, mem_d1);
        end else begin
          e1 = q1.pop_front();
          checkOutput("w1_addr", 32'(mem_a1), e1.a);
          checkOutput("w1_data", 32'(mem_d1), e1.d);
          checkOutput("w1_cycle", 32'(cyc), 32'(e1.c));
          checkOutput("w1_fv", 32'(frame_valid1), 32'd1);
          checkOutput("w1_rw", 32'(mem_rw1), 32'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached, expected normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset();

    for (int m = 0; m < 8; m++) begin
      applyStimulus(0, (32'(m) << 18) | (32'h2AAAA ^ 32'(m)), 21, 1'b1, 1);
      if (m == 6) checkOutput("t1_done_before_8th", 32'(done0), 32'd0);
    end
    idle(0, 2);
    checkOutput("t1_done", 32'(done0), 32'd1);
    applyStimulus(0, 32'h3FFFF, 21, 1'b0, 1);
    idle(0, 2);
    checkOutput("t1_done_sticky", 32'(done0), 32'd1);

    do_reset();
    for (int m = 0; m < 3; m++)
      applyStimulus(0, (32'(m) << 18) | (32'h100 + 32'(m)), 21, 1'b1, 1);
    exp_el0++;
    applyStimulus(0, 32'hABC, 12, 1'b0, 1);
    idle(0, 2);
    checkOutput("t3_short_err_len", 32'(el_cnt0), 32'(exp_el0));
    applyStimulus(0, (32'd3 << 18) | 32'h00001, 21, 1'b1, 1);
    exp_el0++;
    applyStimulus(0, (((32'd4 << 18) | 32'h2BCDE) << 4) | 32'hA, 25, 1'b1, 1);
    applyStimulus(0, (32'd5 << 18) | 32'h15555, 21, 1'b1, 1);
    idle(0, 2);
    checkOutput("t4_overlong_err_len", 32'(el_cnt0), 32'(exp_el0));

    for (int i = 0; i < 6; i++) drive(0, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b1);
    idle(0, 2);
    for (int i = 0; i < 25; i++) drive(0, 1'b0, 1'b0, 1'(i & 1));
    idle(0, 2);
    checkOutput("en_drop_no_err", 32'(el_cnt0), 32'(exp_el0));
    applyStimulus(0, (32'd6 << 18) | 32'h3C3C3, 21, 1'b1, 1);

    do_reset();
    for (int m = 0; m < 4; m++)
      applyStimulus(0, (32'(m) << 18) | (32'h20000 + 32'(m)), 21, 1'b1, 1);
    for (int i = 0; i < 10; i++) drive(0, 1'b1, 1'b0, 1'(i % 3 == 0));
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_async_rw", 32'(mem_rw0), 32'd1);
    checkOutput("t5_async_done", 32'(done0), 32'd0);
    idle(0, 2);
    @(negedge clk);
    rst = 1'b1;
    for (int m = 0; m < 8; m++) begin
      applyStimulus(0, (32'(m) << 18) | (32'h1F0F0 + 32'(m)), 21, 1'b1, 1);
      if (m == 6) checkOutput("t5_done_after_7", 32'(done0), 32'd0);
    end
    idle(0, 2);
    checkOutput("t5_done_after_8", 32'(done0), 32'd1);

    do_reset();
    applyStimulus(0, (32'd0 << 18) | 32'h00AA0, 21, 1'b1, 1);
    applyStimulus(0, (32'd1 << 18) | 32'h00AA1, 21, 1'b1, 1);
    exp_es0 += int'(SEQ);
    applyStimulus(0, (32'd3 << 18) | 32'h00AA3, 21, !SEQ, 1);
    applyStimulus(0, (32'd2 << 18) | 32'h00AA2, 21, 1'b1, 1);
    idle(0, 3);
    checkOutput("t6_err_seq", 32'(es_cnt0), 32'(exp_es0));

    for (int m = 0; m < 18; m++) begin
      applyStimulus(1, (32'(m) << 8) | (32'h5A + 32'(m)), 13, 1'b1, 1);
      if (m == 16) checkOutput("t2_done_before_18th", 32'(done1), 32'd0);
    end
    idle(1, 2);
    checkOutput("t2_done", 32'(done1), 32'd1);

    idle(0, 3);
    checkOutput("pending_writes0", 32'(q0.size()), 32'd0);
    checkOutput("pending_writes1", 32'(q1.size()), 32'd0);
    checkOutput("final_err_len0", 32'(el_cnt0), 32'(exp_el0));
    checkOutput("final_err_len1", 32'(el_cnt1), 32'd0);
    checkOutput("final_err_seq1", 32'(es_cnt1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
